// File: rtl/fifo_rd_arbiter.sv
// Purpose : round-robin sharing of one FWFT FIFO read port between N requesters, in bursts of up to BURST words.
// Latency : a grant is taken one cycle after req and non-empty are seen in IDLE; each word is acked in the same cycle it is popped.
// Backpr. : a pop happens only while the granted requester holds req and the FIFO is non-empty; an empty FIFO holds the grant.
//
// Ports:
//   rd_clk, rst    clock and synchronous active-high reset (reset also blocks the pop combinationally)
//   req[N]         level "want words" per requester
//   fifo_empty     FWFT empty flag
//   fifo_dout      FWFT head word
//   fifo_rd_en     pop strobe
//   ack[N]         one-hot: dout belongs to that requester this cycle
//   dout           pass-through of fifo_dout
//   gnt_valid      a burst is in progress
//   gnt_idx        current or most recent grant holder
//   underrun_cnt   saturating count of cycles with a request pending and the FIFO empty
//
// Build option: define FIFO_ARB_PRIORITY_EN to make requester 0 strict-high-priority.
// It then wins every IDLE arbitration and preempts other bursts.
// In that mode, only non-zero grants advance the rotation pointer.

module fifo_rd_arbiter #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int IDX_W = 2,
    parameter int BURST = 4
) (
    input  logic             rd_clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd_en,
    output logic [N-1:0]     ack,
    output logic [WIDTH-1:0] dout,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [7:0]       underrun_cnt
);

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       underrun_q, underrun_d;

    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] nxt_ptr;
    logic             own_req;
    logic             pop;
    logic             preempt;
    logic             burst_end;

    // Round-robin search starting at rr_ptr.
    // Iterating from the far end downwards lets the nearest requesting index overwrite the others.
    always_comb begin
        sel_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int               j;
            logic [IDX_W-1:0] jj;
            j = int'(rr_ptr_q) + k;
            if (j >= N) begin
                j = j - N;
            end
            jj = IDX_W'(j);
            if (req[jj]) begin
                sel_idx = jj;
            end
        end
`ifdef FIFO_ARB_PRIORITY_EN
        if (req[0]) begin
            sel_idx = '0;
        end
`endif
    end

    assign own_req = req[gnt_idx_q];
    assign pop     = (state_q == ST_BURST) & own_req & ~fifo_empty & ~rst;
    assign nxt_ptr = (gnt_idx_q == IDX_W'(N - 1)) ? '0 : gnt_idx_q + 1'b1;

`ifdef FIFO_ARB_PRIORITY_EN
    assign preempt = (gnt_idx_q != '0) & req[0];
`else
    assign preempt = 1'b0;
`endif

    assign burst_end = (pop & (cnt_q == 8'(BURST - 1))) | ~own_req | preempt;

    always_comb begin
        state_d   = state_q;
        gnt_idx_d = gnt_idx_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if ((|req) && !fifo_empty) begin
                    state_d   = ST_BURST;
                    gnt_idx_d = sel_idx;
                    cnt_d     = '0;
                end
            end
            ST_BURST: begin
                if (pop) begin
                    cnt_d = cnt_q + 8'd1;
                end
                // An empty FIFO with the owner still requesting falls through here: the grant is kept.
                if (burst_end) begin
                    state_d = ST_IDLE;
`ifdef FIFO_ARB_PRIORITY_EN
                    if (gnt_idx_q != '0) begin
                        rr_ptr_d = nxt_ptr;
                    end
`else
                    rr_ptr_d = nxt_ptr;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        underrun_d = underrun_q;
        if ((|req) && fifo_empty && (underrun_q != 8'hFF)) begin
            underrun_d = underrun_q + 8'd1;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_idx_q  <= '0;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            underrun_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_idx_q  <= gnt_idx_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            underrun_q <= underrun_d;
        end
    end

    assign fifo_rd_en   = pop;
    assign ack          = pop ? (N'(1) << gnt_idx_q) : '0;
    assign dout         = fifo_dout;
    assign gnt_valid    = (state_q == ST_BURST);
    assign gnt_idx      = gnt_idx_q;
    assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Purpose : self-checking bench for fifo_rd_arbiter with a queue-based FWFT FIFO and a behavioural arbiter model.
// Latency : outputs are sampled 1ns after inputs settle, mid-cycle; the FIFO queue pops at the clock edge when fifo_rd_en was seen.
// Backpr. : requesters are scripted or random level requests; the FIFO is filled by the bench between cycles.

module tb_fifo_rd_arbiter;

    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int IDX_W = 2;
    localparam int BURST = 4;
`ifdef FIFO_ARB_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic             rd_clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_rd_en;
    logic [N-1:0]     ack;
    logic [WIDTH-1:0] dout;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt_idx;
    logic [7:0]       underrun_cnt;

    fifo_rd_arbiter #(.WIDTH(WIDTH), .N(N), .IDX_W(IDX_W), .BURST(BURST)) dut (
        .rd_clk       (rd_clk),
        .rst          (rst),
        .req          (req),
        .fifo_empty   (fifo_empty),
        .fifo_dout    (fifo_dout),
        .fifo_rd_en   (fifo_rd_en),
        .ack          (ack),
        .dout         (dout),
        .gnt_valid    (gnt_valid),
        .gnt_idx      (gnt_idx),
        .underrun_cnt (underrun_cnt)
    );

    always #5 rd_clk = ~rd_clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [WIDTH-1:0] fq[$];
    logic [WIDTH-1:0] junk;

    // Sampled outputs of the most recent cycle.
    logic             s_rd_en;
    logic [N-1:0]     s_ack;
    logic [WIDTH-1:0] s_dout;
    logic             s_gv;
    logic [IDX_W-1:0] s_gi;
    logic [7:0]       s_ur;

    // Behavioural model: owner -1 means nobody holds the grant.
    int m_owner = -1;
    int m_gi    = 0;
    int m_next  = 0;
    int m_taken = 0;
    int m_under = 0;
    bit m_known = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit req_bit(input int i);
        return bit'((req >> i) & 1);
    endfunction

    task automatic model_step();
        bit ne;
        bit pop;
        int c;
        ne  = (fq.size() != 0);
        pop = !rst && (m_owner >= 0) && req_bit(m_owner) && ne;
        if (m_known) begin
            chk("rd_en", int'(s_rd_en), int'(pop));
            chk("ack", int'(s_ack), pop ? (1 << m_owner) : 0);
            chk("gnt_valid", int'(s_gv), int'(m_owner >= 0));
            chk("gnt_idx", int'(s_gi), m_gi);
            chk("underrun_cnt", int'(s_ur), m_under);
        end
        if (ne) chk("dout", int'(s_dout), int'(fq[0]));
        if (rst) begin
            m_owner = -1; m_gi = 0; m_next = 0; m_taken = 0; m_under = 0; m_known = 1'b1;
        end else begin
            if (req != 0 && !ne && m_under < 255) m_under++;
            if (m_owner < 0) begin
                if (req != 0 && ne) begin
                    c = -1;
                    if (PRIO && req_bit(0)) c = 0;
                    for (int k = 0; k < N; k++) begin
                        if (c < 0 && req_bit((m_next + k) % N)) c = (m_next + k) % N;
                    end
                    m_owner = c; m_gi = c; m_taken = 0;
                end
            end else begin
                if (pop) m_taken++;
                if ((pop && m_taken == BURST) || !req_bit(m_owner) ||
                    (PRIO && m_owner != 0 && req_bit(0))) begin
                    if (!PRIO || m_owner != 0) m_next = (m_owner + 1) % N;
                    m_owner = -1;
                end
            end
        end
    endtask

    // One clock cycle: present the FIFO head, sample, check against the model, then clock.
    task automatic step();
        fifo_empty = (fq.size() == 0);
        fifo_dout  = fifo_empty ? '0 : fq[0];
        #1;
        s_rd_en = fifo_rd_en; s_ack = ack; s_dout = dout;
        s_gv = gnt_valid; s_gi = gnt_idx; s_ur = underrun_cnt;
        model_step();
        @(posedge rd_clk);
        if (s_rd_en && fq.size() != 0) junk = fq.pop_front();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; fq.delete();
        step(); step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0]     req;
        logic             rd_en;
        logic [N-1:0]     ack;
        logic [WIDTH-1:0] dout;
        logic             gv;
        logic [IDX_W-1:0] gi;
    } vec_t;

    vec_t tbl[12];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        int acks, first_other, cnt3;
        bit done, seen, multi;
        int order[$];

        rst = 1'b1; req = '0; fifo_empty = 1'b1; fifo_dout = '0;

        // Single requester, burst / idle / burst pattern.
        tbl[0]  = '{4'b0010, 1'b0, 4'b0000, 8'h10, 1'b0, 2'd0};
        tbl[1]  = '{4'b0010, 1'b1, 4'b0010, 8'h10, 1'b1, 2'd1};
        tbl[2]  = '{4'b0010, 1'b1, 4'b0010, 8'h11, 1'b1, 2'd1};
        tbl[3]  = '{4'b0010, 1'b1, 4'b0010, 8'h12, 1'b1, 2'd1};
        tbl[4]  = '{4'b0010, 1'b1, 4'b0010, 8'h13, 1'b1, 2'd1};
        tbl[5]  = '{4'b0010, 1'b0, 4'b0000, 8'h14, 1'b0, 2'd1};
        tbl[6]  = '{4'b0010, 1'b1, 4'b0010, 8'h14, 1'b1, 2'd1};
        tbl[7]  = '{4'b0010, 1'b1, 4'b0010, 8'h15, 1'b1, 2'd1};
        tbl[8]  = '{4'b0010, 1'b1, 4'b0010, 8'h16, 1'b1, 2'd1};
        tbl[9]  = '{4'b0010, 1'b1, 4'b0010, 8'h17, 1'b1, 2'd1};
        tbl[10] = '{4'b0010, 1'b0, 4'b0000, 8'h18, 1'b0, 2'd1};
        tbl[11] = '{4'b0010, 1'b1, 4'b0010, 8'h18, 1'b1, 2'd1};

        do_reset();
        chk("reset_gnt_valid", int'(gnt_valid), 0);
        chk("reset_gnt_idx", int'(gnt_idx), 0);
        chk("reset_underrun", int'(underrun_cnt), 0);
        for (int i = 0; i < 10; i++) fq.push_back(8'(8'h10 + i));
        for (int i = 0; i < 12; i++) begin
            req = tbl[i].req;
            step();
            chk($sformatf("tbl%0d_rd_en", i), int'(s_rd_en), int'(tbl[i].rd_en));
            chk($sformatf("tbl%0d_ack", i), int'(s_ack), int'(tbl[i].ack));
            chk($sformatf("tbl%0d_dout", i), int'(s_dout), int'(tbl[i].dout));
            chk($sformatf("tbl%0d_gv", i), int'(s_gv), int'(tbl[i].gv));
            chk($sformatf("tbl%0d_gi", i), int'(s_gi), int'(tbl[i].gi));
        end

        // Round-robin rotation with all four requesting.
        do_reset();
        for (int i = 0; i < 16; i++) fq.push_back(8'(8'h20 + i));
        req = 4'b1111; multi = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if ($countones(s_ack) > 1) multi = 1'b1;
            for (int b = 0; b < N; b++) if (s_ack[b]) order.push_back(b);
        end
        chk("rr_onehot", int'(multi), 0);
        chk("rr_count", order.size(), 16);
        for (int i = 0; i < 16 && i < order.size(); i++) chk($sformatf("rr_order%0d", i), order[i], i / 4);
        fq.push_back(8'h55);
        step();
        chk("rr_wrap_gnt", int'(gnt_idx), 0);

        // Early release by requester 2 after two words.
        do_reset();
        for (int i = 0; i < 8; i++) fq.push_back(8'(8'h40 + i));
        req = 4'b0100; acks = 0; done = 1'b0;
        for (int c = 0; c < 10 && !done; c++) begin
            step();
            if (s_ack == 4'b0100) acks++;
            if (acks == 2) begin
                req = 4'b0000;
                step();
                if (s_ack != 0) acks++;
                done = 1'b1;
            end
        end
        chk("release_acks", acks, 2);
        chk("release_idle", int'(gnt_valid), 0);
        req = 4'b1111;
        step();
        chk("release_next_gnt", int'(gnt_idx), 3);
        chk("release_next_gv", int'(gnt_valid), 1);

        // Underrun saturation, then recovery when one word arrives.
        do_reset();
        req = 4'b0001;
        for (int c = 0; c < 300; c++) step();
        chk("underrun_sat", int'(underrun_cnt), 255);
        fq.push_back(8'hA5);
        seen = 1'b0;
        for (int c = 0; c < 2 && !seen; c++) begin
            step();
            if (s_ack == 4'b0001) begin
                seen = 1'b1;
                chk("underrun_word", int'(s_dout), 8'hA5);
            end
        end
        chk("underrun_recover_ack", int'(seen), 1);

        // Reset on the second pop cycle of a burst.
        do_reset();
        for (int i = 0; i < 8; i++) fq.push_back(8'(8'h60 + i));
        req = 4'b0001;
        step();
        step();
        rst = 1'b1;
        step();
        chk("midrst_rd_en", int'(s_rd_en), 0);
        chk("midrst_ack", int'(s_ack), 0);
        rst = 1'b0;
        chk("midrst_gv", int'(gnt_valid), 0);
        chk("midrst_gi", int'(gnt_idx), 0);
        chk("midrst_ur", int'(underrun_cnt), 0);
        chk("midrst_fifo_level", fq.size(), 7);

        // Requester 0 rising during requester 3's burst.
        do_reset();
        for (int i = 0; i < 12; i++) fq.push_back(8'(8'h80 + i));
        req = 4'b1000; cnt3 = 0; first_other = -1;
        step();
        step();
        if (s_ack == 4'b1000) cnt3++;
        req = 4'b1001;
        for (int c = 0; c < 8; c++) begin
            step();
            if (s_ack == 4'b1000) cnt3++;
            else if (s_ack != 0 && first_other < 0) first_other = $clog2(int'(s_ack));
        end
        chk("prio_acks_to_3", cnt3, PRIO ? 2 : 4);
        chk("prio_next_owner", first_other, 0);

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
            if ($urandom_range(0, 2) != 0 && fq.size() < 20) fq.push_back(WIDTH'($urandom));
            step();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_rd_arbiter.md
Name: fifo_rd_arbiter

Overview:
- Shares the read side of one first-word-fall-through (FWFT) FIFO between N requesters in the rd_clk domain, e.g. audio/video consumers behind the cross-clock FIFO.
- Arbitrates round-robin and grants bursts of up to BURST words per turn.
- Drives the FIFO pop strobe and returns each popped word to the granted requester with a same-cycle ack.
- Counts underrun cycles for debug.

Parameters:
- WIDTH, 8, FIFO data width.
- N, 4, number of requesters (2..16).
- IDX_W, 2, width of the grant index; 2**IDX_W >= N.
- BURST, 4, maximum words per grant (1..255).

Ports:
- rd_clk  in  1  read-domain clock, all state on posedge.
- rst  in  1  reset, synchronous, active-high; clock rd_clk.
- req  in  N  per-requester level request: "want words".
- fifo_empty  in  1  FWFT FIFO empty flag.
- fifo_dout  in  WIDTH  FWFT FIFO head word, valid while !fifo_empty.
- fifo_rd_en  out  1  pop strobe to FIFO.
- ack  out  N  one-hot; ack[i]=1 means dout is a word for requester i, popped this cycle.
- dout  out  WIDTH  equals fifo_dout (combinational pass-through).
- gnt_valid  out  1  a requester currently holds the grant.
- gnt_idx  out  IDX_W  index of the current grant holder.
- underrun_cnt  out  8  saturating count of starved cycles.

Behaviour:
Registers and reset:
- Registers: state {IDLE, BURST}, gnt_idx, rr_ptr (IDX_W), cnt (8 bit), underrun_cnt.
- rst=1 at a clock edge: state=IDLE, gnt_idx=0, rr_ptr=0, cnt=0, underrun_cnt=0.
- While rst=1, fifo_rd_en and ack are forced 0 combinationally. This also applies mid-burst; no pop occurs in a reset cycle.

Round-robin select (combinational):
- Search order is rr_ptr, rr_ptr+1, ..., N-1, 0, ..., rr_ptr-1.
- Selected index = first i in that order with req[i]=1.

IDLE:
- If |req and !fifo_empty: load gnt_idx = selected index, cnt=0, go to BURST.
- Otherwise stay in IDLE.
- No pop in IDLE. gnt_valid=0.

BURST:
- gnt_valid=1.
- pop = req[gnt_idx] & !fifo_empty.
- fifo_rd_en = pop; ack = pop ? (1<<gnt_idx) : 0.
- On pop, cnt increments.
- Exit to IDLE with rr_ptr = (gnt_idx+1) mod N when any of the following holds:
  - pop and cnt == BURST-1 (burst exhausted);
  - req[gnt_idx] = 0 (requester released);
  - the priority-preempt condition below fires.
- If req[gnt_idx]=1 and fifo_empty: hold BURST and wait. The grant is kept because no word is available to anyone else.

Timing:
- Latency: req[i] rises in cycle t with FIFO non-empty and arbiter idle → BURST at t+1 → first ack[i] at t+1 if req[i] is still high.
- At most one word per cycle.
- A requester wanting k words keeps req high until it has seen k acks, and drops req in the cycle after the k-th ack.
- Because ack is same-cycle with req, a requester never receives an unrequested word.
- Back-to-back grants cost one IDLE cycle between bursts.

Underrun counting:
- underrun_cnt increments when |req and fifo_empty and !rst.
- Saturates at 255; no wrap.

Boundary cases:
- BURST=1: every grant is one word, then rotate.
- rr_ptr wraps from N-1 to 0.
- A single requester with req held receives BURST words, 1 idle cycle, BURST words, and so on.
- Req changes on non-granted lines during BURST are ignored until IDLE.

Optional Feature:
FIFO_ARB_PRIORITY_EN
- Defined:
  - Requester 0 is strict-high-priority. In IDLE it wins whenever req[0]=1, regardless of rr_ptr.
  - In BURST with gnt_idx != 0, the burst ends after any cycle where req[0]=1. This happens on the pop cycle, or immediately if no pop occurred.
  - rr_ptr is updated only by non-zero grants.
- Undefined: pure round-robin as above; req[0] has no special treatment.

Test Plan:
- Reset then single requester: N=4, BURST=4, FIFO holds 0x10..0x19, req=0b0010 held → acks on 4 consecutive cycles with dout 0x10..0x13; 1 idle cycle; then 0x14..0x17; gnt_idx=1 throughout.
- Round-robin rotation: req=0b1111 held, FIFO 16 words → grants in order 0,1,2,3, each 4 words; rr_ptr returns to 0; no word acked to two requesters.
- Early release: req[2] high, dropped the cycle after its 2nd ack → exactly 2 acks to requester 2; arbiter returns to IDLE; rr_ptr=3.
- Underrun: FIFO empty, req=0b0001 for 300 cycles → no fifo_rd_en; underrun_cnt saturates at 255. Write 1 word → ack[0] within 2 cycles with that word.
- Mid-burst reset: rst asserted on the 2nd pop cycle of a burst → fifo_rd_en=0 that cycle; all registers zero next cycle; FIFO word count drops by exactly 1.
- With FIFO_ARB_PRIORITY_EN: req[3] bursting, req[0] rises → requester 3 ends after the current word; requester 0 is granted after one IDLE cycle. Without the macro, requester 3 completes its 4-word burst first.
